branch_history_table: RTL and testbench
=======================================

Name: branch_history_table

Overview:
- Per-PC 2-bit saturating-counter direction predictor in the fetch stage of the LC-3b pipeline.
- Sits directly upstream of the branch target buffer and supplies its istaken input.
- Lookup is combinational in the same cycle as the fetch PC.
- Trained by resolved-branch updates from the execute/memory stage.
- After reset, an init sweep clears the table before predictions are valid.

Parameters:
- ENTRIES, 64, number of counters; must be a power of two, at least 4.
- IDX_W, $clog2(ENTRIES), index width; derived, do not override.
- CTR_INIT, 2'b01, counter value written during the init sweep (weakly not-taken).

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- pc  input  16 (lc3b_word)  current fetch PC.
- pred_taken  output  1  predicted direction for pc; feeds the BTB istaken.
- pred_valid  output  1  high when the table is initialised and the prediction is meaningful.
- upd_valid  input  1  a resolved conditional branch is presented this cycle.
- upd_pc  input  16 (lc3b_word)  PC of the resolved branch.
- upd_taken  input  1  actual branch outcome.
- init_busy  output  1  high while the init sweep runs.

Behaviour:
- Index: idx = pc[IDX_W:1]; pc[0] is ignored (word aligned). The update index is formed the same way from upd_pc.
- Storage: ENTRIES x 2-bit counters. The MSB is the direction; 1 means taken.
- State machine has two states, INIT and READY.
  - rst=1 at any posedge moves to INIT with init_ptr=0. This includes reset mid-sweep or mid-operation, which restarts the sweep from 0.
  - In INIT, every posedge writes CTR_INIT to entry[init_ptr] and increments init_ptr.
  - When init_ptr==ENTRIES-1 is written, the next state is READY. The sweep lasts exactly ENTRIES cycles after rst deasserts.
  - READY persists until the next rst.
- Outputs during rst and INIT:
  - init_busy=1, pred_valid=0, pred_taken=0.
  - upd_valid is ignored; the update is dropped and not queued.
- Outputs in READY:
  - init_busy=0, pred_valid=1.
  - pred_taken = entry[idx][1], combinational from pc with zero latency.
- Update, in READY with upd_valid=1, at posedge:
  - upd_taken=1: counter increments, saturating at 2'b11.
  - upd_taken=0: counter decrements, saturating at 2'b00.
  - One update per cycle maximum.
- Same-cycle read/update to the same index: pred_taken reflects the pre-update value, with no bypass. The new value is visible the following cycle.
- Counter values are only ever 00, 01, 10 or 11; wrap-around is forbidden.

Optional Feature:
- Macro: BHT_GSHARE_EN.
- When defined:
  - Adds an IDX_W-bit global history register ghr, reset to 0 by rst.
  - Lookup index = pc[IDX_W:1] ^ ghr.
  - Update index = upd_pc[IDX_W:1] ^ ghr, using the value before this cycle's shift.
  - On each accepted update, ghr <= {ghr[IDX_W-2:0], upd_taken}. The history is non-speculative and updated at resolve only.
  - ghr does not shift during INIT.
- When undefined: no ghr exists and indexing is pure PC bits as above.

Decomposition:
- lc3b_type package: reuse lc3b_word.
- Add to lc3b_type:
  - typedef lc3b_bht_ctr (logic [1:0]).
  - constants BHT_STRONG_NT=2'b00, BHT_WEAK_NT=2'b01, BHT_WEAK_T=2'b10, BHT_STRONG_T=2'b11.
- One natural sub-module: sat_counter2. Purely combinational next-value function: inputs ctr and taken, output the saturated next ctr. Instantiated once on the update path.
- The table, init FSM and ghr stay in branch_history_table.

Test Plan:
1. Reset sequencing: pulse rst 1 cycle. Required response:
   - init_busy=1 and pred_valid=0 for exactly 64 cycles.
   - Then pred_valid=1, and every pc returns pred_taken=0 (entries are 01).
2. Saturation: pc=16'h0040, apply 3 upd_taken=1 updates. Required response:
   - pred_taken=1 after the 1st update (01->10).
   - Counter holds at 11 after the 3rd.
   - Two upd_taken=0 updates leave it at 01, so pred_taken=0.
3. Same-cycle collision: pc=upd_pc=16'h0102 with counter 01 and upd_taken=1. Required response: pred_taken=0 that cycle and 1 the next cycle.
4. Aliasing and pc[0] ignore:
   - upd_pc=16'h0002 trained taken twice.
   - Lookups at 16'h0003 and 16'h0082 (both idx 1 with ENTRIES=64) both give pred_taken=1.
   - 16'h0004 gives pred_taken=0.
5. Reset mid-sweep and updates during INIT:
   - Assert rst at sweep cycle 30 while driving upd_valid=1. Required response: the sweep restarts, and 64 cycles follow before pred_valid=1.
   - Train entry 5 taken before the reset. Required response: it reads 0 afterwards.
6. (BHT_GSHARE_EN) Global-history indexing:
   - Updates upd_pc=0x0002 taken, then upd_pc=0x0004 not-taken. Required response: ghr goes 0 -> 1 -> 2.
   - With ghr=2, a lookup at pc=0x0004 indexes entry 2^2=0.

Source files
------------

// File: rtl/branch_history_table_pkg.sv
// Shared LC-3b types plus the branch history table's counter type,
// counter encodings and the init/ready state encoding.
package lc3b_type;

    typedef logic [15:0] lc3b_word;

    // 2-bit direction counter; MSB set means predict taken.
    typedef logic [1:0] lc3b_bht_ctr;

    localparam lc3b_bht_ctr BHT_STRONG_NT = 2'b00;
    localparam lc3b_bht_ctr BHT_WEAK_NT   = 2'b01;
    localparam lc3b_bht_ctr BHT_WEAK_T    = 2'b10;
    localparam lc3b_bht_ctr BHT_STRONG_T  = 2'b11;

    // Table lifecycle: INIT while the clearing sweep runs, READY afterwards.
    typedef enum logic {
        BHT_INIT  = 1'b0,
        BHT_READY = 1'b1
    } bht_state_e;

endpackage

// File: rtl/branch_history_table_sat_counter2.sv
// Saturating 2-bit counter step: moves one toward taken or not-taken,
// holding at 2'b11 / 2'b00 instead of wrapping. Purely combinational.
module sat_counter2
    import lc3b_type::*;
(
    input  lc3b_bht_ctr ctr,
    input  logic        taken,
    output lc3b_bht_ctr ctr_next
);

    // Next counter value, clamped at both ends.
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != BHT_STRONG_T) begin
                ctr_next = ctr + 2'b01;
            end
        end else begin
            if (ctr != BHT_STRONG_NT) begin
                ctr_next = ctr - 2'b01;
            end
        end
    end

endmodule

// File: rtl/branch_history_table.sv
// Per-PC 2-bit direction predictor for the LC-3b fetch stage.
// Lookup is combinational from pc; training comes from resolved branches.
// After reset an ENTRIES-cycle sweep writes CTR_INIT to every counter.
// Optional build macro: BHT_GSHARE_EN -- XORs a non-speculative global
// history register into both the lookup and the update index.
//
// Handshake: upd_valid is a single-cycle strobe with no ready; an update is
// accepted only at a posedge where rst=0 and the table is READY. Updates
// presented during reset or the init sweep are dropped, never queued.
module branch_history_table
    import lc3b_type::*;
#(
    parameter int          ENTRIES  = 64,
    parameter lc3b_bht_ctr CTR_INIT = BHT_WEAK_NT
) (
    input  logic     clk,
    input  logic     rst,
    input  lc3b_word pc,
    output logic     pred_taken,
    output logic     pred_valid,
    input  logic     upd_valid,
    input  lc3b_word upd_pc,
    input  logic     upd_taken,
    output logic     init_busy
);

    localparam int IDX_W = $clog2(ENTRIES);

    bht_state_e        state_q, state_d;
    logic [IDX_W-1:0]  init_ptr_q, init_ptr_d;
    lc3b_bht_ctr       table_q [ENTRIES];
    lc3b_bht_ctr       table_d [ENTRIES];

    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              upd_accept;
    lc3b_bht_ctr       upd_ctr_next;

    // pc[0] is always ignored (word aligned); high bits alias by design.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc[15:IDX_W+1], pc[0], upd_pc[15:IDX_W+1], upd_pc[0]};

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0]  ghr_q, ghr_d;

    // Both indices use the history as it stands before this cycle's shift.
    assign rd_idx = pc[IDX_W:1] ^ ghr_q;
    assign wr_idx = upd_pc[IDX_W:1] ^ ghr_q;
`else
    assign rd_idx = pc[IDX_W:1];
    assign wr_idx = upd_pc[IDX_W:1];
`endif

    // Prediction is meaningful only once the sweep has finished and reset is low.
    assign pred_valid = ~rst & (state_q == BHT_READY);
    assign init_busy  = ~pred_valid;
    // No bypass: a same-cycle update to rd_idx shows up next cycle.
    assign pred_taken = pred_valid & table_q[rd_idx][1];
    assign upd_accept = pred_valid & upd_valid;

    sat_counter2 u_sat_counter2 (
        .ctr      (table_q[wr_idx]),
        .taken    (upd_taken),
        .ctr_next (upd_ctr_next)
    );

    // Next state: sweep pointer advance, table writes and history shift.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        table_d    = table_q;
`ifdef BHT_GSHARE_EN
        ghr_d      = ghr_q;
`endif
        if (!rst) begin
            unique case (state_q)
                BHT_INIT: begin
                    table_d[init_ptr_q] = CTR_INIT;
                    init_ptr_d          = init_ptr_q + 1'b1;
                    if (init_ptr_q == IDX_W'(ENTRIES - 1)) begin
                        state_d = BHT_READY;
                    end
                end
                BHT_READY: begin
                    if (upd_accept) begin
                        table_d[wr_idx] = upd_ctr_next;
`ifdef BHT_GSHARE_EN
                        ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
`endif
                    end
                end
                default: state_d = BHT_INIT;
            endcase
        end
    end

    // Control registers: reset restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BHT_INIT;
            init_ptr_q <= '0;
`ifdef BHT_GSHARE_EN
            ghr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
`ifdef BHT_GSHARE_EN
            ghr_q      <= ghr_d;
`endif
        end
    end

    // Counter storage; cleared by the sweep rather than by reset.
    always_ff @(posedge clk) begin
        table_q <= table_d;
    end

endmodule

// File: tb/tb_branch_history_table.sv
// Bench for branch_history_table: directed scenarios followed by random
// traffic, every cycle scored against a behavioural predictor model.
module tb_branch_history_table;

    localparam int ENTRIES = 64;

    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic        pred_taken;
    logic        pred_valid;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic        init_busy;

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_q[$];
    string      name_q[$];

    // Reference model state
    int m_ctr[ENTRIES];
    bit m_ready;
    int m_init_left;
    int m_ghr;

    branch_history_table dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pred_taken (pred_taken),
        .pred_valid (pred_valid),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .init_busy  (init_busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic int pc_idx(input logic [15:0] p);
        int i;
        i = (int'(p) >> 1) % ENTRIES;
`ifdef BHT_GSHARE_EN
        i = i ^ m_ghr;
`endif
        return i;
    endfunction

    // Expected {init_busy, pred_valid, pred_taken} for the current inputs.
    function automatic logic [2:0] model_expect();
        if (rst || !m_ready) return 3'b100;
        return {1'b0, 1'b1, (m_ctr[pc_idx(pc)] >= 2) ? 1'b1 : 1'b0};
    endfunction

    // What a clock edge does to the predictor, given the held inputs.
    task automatic model_clock();
        int i;
        if (rst) begin
            m_ready     = 0;
            m_init_left = ENTRIES;
            m_ghr       = 0;
        end else if (!m_ready) begin
            m_init_left = m_init_left - 1;
            if (m_init_left == 0) begin
                for (int k = 0; k < ENTRIES; k++) m_ctr[k] = 1;
                m_ready = 1;
            end
        end else if (upd_valid) begin
            i = pc_idx(upd_pc);
            if (upd_taken) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            else           m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            m_ghr = ((m_ghr << 1) | (upd_taken ? 1 : 0)) % ENTRIES;
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit r, input logic [15:0] p, input bit uv,
                        input logic [15:0] up, input bit ut, input string nm);
        rst       = r;
        pc        = p;
        upd_valid = uv;
        upd_pc    = up;
        upd_taken = ut;
        exp_q.push_back(model_expect());
        name_q.push_back(nm);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle(input int n, input string nm);
        for (int k = 0; k < n; k++)
            step(1'b0, 16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)), nm);
    endtask

    task automatic reset_pulse(input string nm);
        step(1'b1, 16'h0000, 1'b1, 16'h0002, 1'b1, nm);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [2:0] e;
        logic [2:0] got;
        string      n;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            n   = name_q.pop_front();
            got = {init_busy, pred_valid, pred_taken};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL %s t=%0t pc=%h {busy,valid,taken} got=%b exp=%b",
                         n, $time, pc, got, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        m_ready     = 0;
        m_init_left = ENTRIES;
        m_ghr       = 0;
        for (int k = 0; k < ENTRIES; k++) m_ctr[k] = 1;
        rst = 1'b1; pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        @(posedge clk);
        #1;

        // 1. reset sequencing: one-cycle pulse, sweep, then all predict not-taken
        reset_pulse("reset");
        idle(ENTRIES, "init_sweep");
        for (int k = 0; k < ENTRIES; k++)
            step(1'b0, 16'(k * 2), 1'b0, 16'h0000, 1'b0, "post_init_read");

        // 2. saturation on pc 0x0040
        for (int k = 0; k < 3; k++)
            step(1'b0, 16'h0040, 1'b1, 16'h0040, 1'b1, "sat_up");
        step(1'b0, 16'h0040, 1'b0, 16'h0000, 1'b0, "sat_hold_11");
        for (int k = 0; k < 2; k++)
            step(1'b0, 16'h0040, 1'b1, 16'h0040, 1'b0, "sat_down");
        step(1'b0, 16'h0040, 1'b0, 16'h0000, 1'b0, "sat_back_01");

        // 3. same-cycle collision: old value this cycle, new value next
        step(1'b0, 16'h0102, 1'b1, 16'h0102, 1'b1, "collide_same");
        step(1'b0, 16'h0102, 1'b0, 16'h0000, 1'b0, "collide_next");

        // 4. aliasing and pc[0] ignored
        step(1'b0, 16'h0004, 1'b1, 16'h0002, 1'b1, "alias_train");
        step(1'b0, 16'h0004, 1'b1, 16'h0002, 1'b1, "alias_train");
        step(1'b0, 16'h0003, 1'b0, 16'h0000, 1'b0, "alias_0003");
        step(1'b0, 16'h0082, 1'b0, 16'h0000, 1'b0, "alias_0082");
        step(1'b0, 16'h0004, 1'b0, 16'h0000, 1'b0, "alias_0004");

        // 5. train entry 5, reset, re-reset mid-sweep with updates pending
        step(1'b0, 16'h000A, 1'b1, 16'h000A, 1'b1, "e5_train");
        step(1'b0, 16'h000A, 1'b1, 16'h000A, 1'b1, "e5_train");
        step(1'b0, 16'h000A, 1'b0, 16'h0000, 1'b0, "e5_taken");
        reset_pulse("reset2");
        for (int k = 0; k < 30; k++)
            step(1'b0, 16'h000A, 1'b1, 16'h000A, 1'b1, "sweep_upd_drop");
        reset_pulse("reset_mid_sweep");
        for (int k = 0; k < ENTRIES; k++)
            step(1'b0, 16'h000A, 1'b1, 16'h000A, 1'b1, "sweep_restart");
        step(1'b0, 16'h000A, 1'b0, 16'h0000, 1'b0, "e5_cleared");

`ifdef BHT_GSHARE_EN
        // 6. global history indexing from a clean table
        reset_pulse("gs_reset");
        idle(ENTRIES, "gs_sweep");
        step(1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, "gs_upd1");
        step(1'b0, 16'h0000, 1'b1, 16'h0004, 1'b0, "gs_upd2");
        step(1'b0, 16'h0004, 1'b1, 16'h0004, 1'b1, "gs_train_e0");
        step(1'b0, 16'h0004, 1'b0, 16'h0000, 1'b0, "gs_lookup");
`endif

        // random traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 299) == 0)
                reset_pulse("rand_reset");
            else
                step(1'b0, 16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                     16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "random");
        end

        upd_valid = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog t=%0t limit=200000", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
